// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic package: subtractor FSM states and parameter legality check
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  // Operand width must be at least 2 bits and split into whole digits.
  function automatic bit sub_params_legal(int data_width, int digit_width);
    return (data_width >= 2) && (digit_width >= 1) &&
           (digit_width <= data_width) && ((data_width % digit_width) == 0);
  endfunction

endpackage

// File: rtl/digit_subtractor.sv
// rtl/digit_subtractor.sv - combinational ripple of full-subtract cells for one digit
module digit_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  logic [WIDTH:0] br;

  assign br[0] = bin;

  // Each cell borrows when a < b + borrow-in at that bit position.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign d[i]    = a[i] ^ b[i] ^ br[i];
    assign br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
  end

  assign bout = br[WIDTH];

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - digit-serial A - B - Borrow_In subtractor with IDLE/RUN/DONE control
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int DIGIT_WIDTH = 4
) (
  input  logic                  Clock_In,
  input  logic                  Reset_In,
  input  logic                  Start_In,
  input  logic [DATA_WIDTH-1:0] Data_A_In,
  input  logic [DATA_WIDTH-1:0] Data_B_In,
  input  logic                  Borrow_In,
  output logic                  Ready_Out,
  output logic                  Busy_Out,
  output logic                  Done_Out,
  output logic [DATA_WIDTH-1:0] Difference_Out,
  output logic                  Borrow_Out,
  output logic                  Zero_Out,
  output logic                  Overflow_Out
);

  localparam int NUM_DIGITS = DATA_WIDTH / DIGIT_WIDTH;
  localparam int CW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int MSB        = DATA_WIDTH - 1;

  if (!sub_params_legal(DATA_WIDTH, DIGIT_WIDTH)) begin : g_illegal_params
    $error("serial_subtractor: DATA_WIDTH must be >= 2 and a multiple of DIGIT_WIDTH");
  end

  sub_state_t             state;
  logic [CW-1:0]          k;
  logic                   run_borrow;
  logic [DATA_WIDTH-1:0]  a_q;
  logic [DATA_WIDTH-1:0]  b_q;
  logic [DATA_WIDTH-1:0]  d_q;
  logic [DATA_WIDTH-1:0]  d_next;
  logic [DIGIT_WIDTH-1:0] digit_a;
  logic [DIGIT_WIDTH-1:0] digit_b;
  logic [DIGIT_WIDTH-1:0] digit_d;
  logic                   digit_bout;
  logic                   last_digit;

  assign digit_a    = a_q[k*DIGIT_WIDTH +: DIGIT_WIDTH];
  assign digit_b    = b_q[k*DIGIT_WIDTH +: DIGIT_WIDTH];
  assign last_digit = (k == CW'(NUM_DIGITS - 1));

  assign Ready_Out  = (state != RUN);
  assign Busy_Out   = (state == RUN);

  digit_subtractor #(
    .WIDTH (DIGIT_WIDTH)
  ) u_digit (
    .a    (digit_a),
    .b    (digit_b),
    .bin  (run_borrow),
    .d    (digit_d),
    .bout (digit_bout)
  );

  // Working difference with the current digit merged in; the last digit's
  // view is the complete result loaded into the outputs on DONE entry.
  always_comb begin
    d_next = d_q;
    d_next[k*DIGIT_WIDTH +: DIGIT_WIDTH] = digit_d;
  end

  // Control FSM, digit counter, operand latches and registered results.
  always_ff @(posedge Clock_In) begin
    if (!Reset_In) begin
      state          <= IDLE;
      k              <= '0;
      run_borrow     <= 1'b0;
      a_q            <= '0;
      b_q            <= '0;
      d_q            <= '0;
      Done_Out       <= 1'b0;
      Difference_Out <= '0;
      Borrow_Out     <= 1'b0;
      Zero_Out       <= 1'b0;
      Overflow_Out   <= 1'b0;
    end else begin
      Done_Out <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (Start_In) begin
            a_q        <= Data_A_In;
            b_q        <= Data_B_In;
            run_borrow <= Borrow_In;
            d_q        <= '0;
            k          <= '0;
            state      <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          d_q        <= d_next;
          run_borrow <= digit_bout;
          if (last_digit) begin
            k              <= '0;
            state          <= DONE;
            Done_Out       <= 1'b1;
            Difference_Out <= d_next;
            Borrow_Out     <= digit_bout;
            Zero_Out       <= (d_next == '0);
            Overflow_Out   <= (a_q[MSB] != b_q[MSB]) && (d_next[MSB] != a_q[MSB]);
          end else begin
            k <= k + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor at DIGIT_WIDTH 1, 4 and 16
module tb_serial_subtractor;

  typedef struct packed {
    logic [15:0] diff;
    logic        borrow;
    logic        zero;
    logic        ovf;
  } res_t;

  logic             clk = 1'b0;
  logic             resetn;
  logic [2:0]       start;
  logic [2:0][15:0] a_in;
  logic [2:0][15:0] b_in;
  logic [2:0]       bin_in;
  logic [2:0]       ready;
  logic [2:0]       busy;
  logic [2:0]       done;
  logic [2:0][15:0] diff;
  logic [2:0]       borrow;
  logic [2:0]       zero;
  logic [2:0]       ovf;

  int   errors = 0;
  int   checks = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int GW = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
    serial_subtractor #(
      .DATA_WIDTH  (16),
      .DIGIT_WIDTH (GW)
    ) dut (
      .Clock_In       (clk),
      .Reset_In       (resetn),
      .Start_In       (start[g]),
      .Data_A_In      (a_in[g]),
      .Data_B_In      (b_in[g]),
      .Borrow_In      (bin_in[g]),
      .Ready_Out      (ready[g]),
      .Busy_Out       (busy[g]),
      .Done_Out       (done[g]),
      .Difference_Out (diff[g]),
      .Borrow_Out     (borrow[g]),
      .Zero_Out       (zero[g]),
      .Overflow_Out   (ovf[g])
    );
  end

  function automatic int num_digits(int i);
    return (i == 0) ? 16 : ((i == 1) ? 4 : 1);
  endfunction

  function automatic res_t model(logic [15:0] a, logic [15:0] b, logic bin);
    logic [16:0] full;
    res_t r;
    full     = {1'b0, a} - {1'b0, b} - {16'b0, bin};
    r.diff   = full[15:0];
    r.borrow = full[16];
    r.zero   = (full[15:0] == 16'h0000);
    r.ovf    = (a[15] != b[15]) && (full[15] != a[15]);
    return r;
  endfunction

  function automatic res_t observe(int i);
    res_t r;
    r.diff   = diff[i];
    r.borrow = borrow[i];
    r.zero   = zero[i];
    r.ovf    = ovf[i];
    return r;
  endfunction

  task automatic launch(int i, logic [15:0] a, logic [15:0] b, logic bin, bit hold);
    start[i]  = 1'b1;
    a_in[i]   = a;
    b_in[i]   = b;
    bin_in[i] = bin;
    @(posedge clk);
    if (!hold) begin
      #1 start[i] = 1'b0;
    end
  endtask

  task automatic wait_done(int i, output int lat, output bit stable);
    res_t snap;
    lat    = -1;
    stable = 1'b1;
    snap   = '0;
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      if (done[i]) begin
        lat = n;
        return;
      end
      if (n == 1) snap = observe(i);
      else if (observe(i) !== snap) stable = 1'b0;
    end
  endtask

  task automatic test_reset();
    resetn   = 1'b0;
    start    = 3'b010;
    a_in[1]  = 16'h1234;
    b_in[1]  = 16'h0234;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    start  = 3'b000;
    @(negedge clk);
    checks++;
    if (ready !== 3'b111) begin
      errors++;
      $display("FAIL reset_ready got=%b want=111", ready);
    end
    checks++;
    if ({busy, done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_busy_done got=%b_%b want=000_000", busy, done);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (observe(i) !== res_t'(0)) begin
        errors++;
        $display("FAIL reset_results inst=%0d got=%h want=0", i, observe(i));
      end
    end
  endtask

  task automatic test_basic();
    logic [15:0] va[5]   = '{16'h1234, 16'h0000, 16'h8000, 16'h0005, 16'h7FFF};
    logic [15:0] vb[5]   = '{16'h0234, 16'h0001, 16'h0001, 16'h0004, 16'hFFFF};
    logic        vbin[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [18:0] vexp[5] = '{{16'h1000, 3'b000}, {16'hFFFF, 3'b100}, {16'h7FFF, 3'b001},
                             {16'h0000, 3'b010}, {16'h8000, 3'b101}};
    int   lat;
    bit   stable;
    res_t e;
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      exp_q.push_back(res_t'(vexp[v]));
      launch(1, va[v], vb[v], vbin[v], 1'b0);
      wait_done(1, lat, stable);
      e = exp_q.pop_front();
      checks++;
      if (lat != 5) begin
        errors++;
        $display("FAIL basic_latency vec=%0d got=%0d want=5", v, lat);
      end
      checks++;
      if (!stable) begin
        errors++;
        $display("FAIL basic_hold_in_run vec=%0d got=changed want=held", v);
      end
      checks++;
      if (observe(1) !== e) begin
        errors++;
        $display("FAIL basic_result vec=%0d got=%h want=%h", v, observe(1), e);
      end
      @(negedge clk);
      checks++;
      if ({done[1], ready[1], busy[1]} !== 3'b010) begin
        errors++;
        $display("FAIL basic_done_pulse vec=%0d got=%b want=010", v, {done[1], ready[1], busy[1]});
      end
    end
  endtask

  task automatic test_back_to_back();
    int   lat;
    bit   stable;
    res_t e;
    @(negedge clk);
    exp_q.push_back(model(16'hA5A5, 16'h5A5A, 1'b1));
    launch(1, 16'hA5A5, 16'h5A5A, 1'b1, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (done[1] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_early_done cycle=%0d got=%b want=0", c, done[1]);
      end
      a_in[1]   = 16'($urandom);
      b_in[1]   = 16'($urandom);
      bin_in[1] = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if ({done[1], observe(1)} !== {1'b1, e}) begin
      errors++;
      $display("FAIL b2b_first got=%b_%h want=1_%h", done[1], observe(1), e);
    end
    exp_q.push_back(model(16'h1234, 16'h0234, 1'b0));
    launch(1, 16'h1234, 16'h0234, 1'b0, 1'b0);
    wait_done(1, lat, stable);
    e = exp_q.pop_front();
    checks++;
    if (lat != 5) begin
      errors++;
      $display("FAIL b2b_second_latency got=%0d want=5", lat);
    end
    checks++;
    if (observe(1) !== e) begin
      errors++;
      $display("FAIL b2b_second_result got=%h want=%h", observe(1), e);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    @(negedge clk);
    launch(1, 16'h4321, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if ({ready[1], busy[1], done[1]} !== 3'b100) begin
      errors++;
      $display("FAIL midrun_state got=%b want=100", {ready[1], busy[1], done[1]});
    end
    checks++;
    if (observe(1) !== res_t'(0)) begin
      errors++;
      $display("FAIL midrun_results got=%h want=0", observe(1));
    end
    resetn = 1'b1;
    seen   = 0;
    repeat (10) begin
      @(negedge clk);
      if (done[1]) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrun_no_done got=%0d pulses want=0", seen);
    end
  endtask

  task automatic test_sweep();
    int          lat;
    bit          stable;
    res_t        e;
    logic [15:0] a;
    logic [15:0] b;
    logic        bi;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      for (int n = 0; n < 1000; n++) begin
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        a  = 16'($urandom);
        b  = 16'($urandom);
        bi = 1'($urandom_range(0, 1));
        exp_q.push_back(model(a, b, bi));
        launch(i, a, b, bi, 1'b0);
        wait_done(i, lat, stable);
        e = exp_q.pop_front();
        checks++;
        if (lat != num_digits(i) + 1) begin
          errors++;
          $display("FAIL sweep_latency inst=%0d op=%0d got=%0d want=%0d", i, n, lat, num_digits(i) + 1);
        end
        checks++;
        if (!stable) begin
          errors++;
          $display("FAIL sweep_hold_in_run inst=%0d op=%0d got=changed want=held", i, n);
        end
        checks++;
        if (observe(i) !== e) begin
          errors++;
          $display("FAIL sweep_result inst=%0d op=%0d a=%h b=%h bin=%b got=%h want=%h",
                   i, n, a, b, bi, observe(i), e);
        end
      end
    end
  endtask

  initial begin
    resetn = 1'b0;
    start  = 3'b000;
    a_in   = '0;
    b_in   = '0;
    bin_in = 3'b000;
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
